// File: rtl/next_pc_predictor.sv
// Fetch-stage next-PC generator: fetch PC register, direct-mapped BTB with 2-bit counters, execute-stage redirect/training.
// Latency: prediction is combinational from pc_o (0 cycles); redirected or predicted PC appears on pc_o one cycle later.
// Backpressure: stall_i holds pc_o; a mispredict redirect overrides the stall; BTB training never stalls.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   stall_i                    front-end stall, holds the fetch PC
//   pc_o                       registered fetch PC
//   pred_taken_o/target_o      prediction for pc_o (BTB target when taken, else pc_o+4)
//   ex_valid_i .. ex_pred_*    execute-stage resolution of a branch/jump plus the prediction it carried
//   redirect_o                 mispredict: flush younger instructions, fetch restarts at the correct PC
//   mispredict_cnt_o           saturating mispredict counter

module next_pc_predictor #(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            ex_valid_i,
  input  logic            ex_is_jump_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            ex_taken_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_target_i,
  output logic            redirect_o,
  output logic [31:0]     mispredict_cnt_o
);

  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  localparam logic [1:0] CTR_RESET  = 2'b01;  // weakly not-taken
  localparam logic [1:0] CTR_JUMP   = 2'b11;  // jumps are always taken
  localparam logic [1:0] CTR_BRANCH = 2'b10;  // first taken branch: weakly taken

  // ---------------------------------------------------------------------------
  // BTB storage
  // ---------------------------------------------------------------------------
  logic             btb_valid  [BTB_ENTRIES];
  logic [TAGW-1:0]  btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]  btb_target [BTB_ENTRIES];
  logic [1:0]       btb_ctr    [BTB_ENTRIES];

  logic [XLEN-1:0]  pc_q;
  logic [31:0]      cnt_q;

  // ---------------------------------------------------------------------------
  // Fetch-side lookup (reads the pre-write state of the current cycle)
  // ---------------------------------------------------------------------------
  logic [IDX-1:0]   lk_idx;
  logic [TAGW-1:0]  lk_tag;
  logic             lk_hit;

  assign lk_idx = pc_q[IDX+1:2];
  assign lk_tag = pc_q[XLEN-1:IDX+2];
  assign lk_hit = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);

  assign pc_o          = pc_q;
  assign pred_taken_o  = lk_hit && btb_ctr[lk_idx][1];
  assign pred_target_o = pred_taken_o ? btb_target[lk_idx] : (pc_q + PC_INC);

  // ---------------------------------------------------------------------------
  // Execute-side resolution
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]  correct_pc;

  // Target only matters when the branch was actually taken; a not-taken
  // branch that was predicted not-taken is correct whatever target it carried.
  assign redirect_o = ex_valid_i &&
                      ((ex_taken_i != ex_pred_taken_i) ||
                       (ex_taken_i && (ex_target_i != ex_pred_target_i)));

  assign correct_pc = ex_taken_i ? ex_target_i : (ex_pc_i + PC_INC);

  // ---------------------------------------------------------------------------
  // Training lookup and counter update
  // ---------------------------------------------------------------------------
  logic [IDX-1:0]   ex_idx;
  logic [TAGW-1:0]  ex_tag;
  logic             ex_hit;
  logic [1:0]       ex_ctr;
  logic [1:0]       ctr_nxt;

  assign ex_idx = ex_pc_i[IDX+1:2];
  assign ex_tag = ex_pc_i[XLEN-1:IDX+2];
  assign ex_hit = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
  assign ex_ctr = btb_ctr[ex_idx];

  always_comb begin
    ctr_nxt = ex_ctr;
    if (ex_taken_i) begin
      if (ex_ctr != 2'b11) ctr_nxt = ex_ctr + 2'd1;
    end else begin
      if (ex_ctr != 2'b00) ctr_nxt = ex_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= CTR_RESET;
      end
    end else if (ex_valid_i) begin
      if (ex_hit) begin
        btb_ctr[ex_idx] <= ctr_nxt;
        if (ex_taken_i) btb_target[ex_idx] <= ex_target_i;
      end else if (ex_taken_i) begin
        // Allocation overwrites whatever aliased into this slot.
        btb_valid[ex_idx]  <= 1'b1;
        btb_tag[ex_idx]    <= ex_tag;
        btb_target[ex_idx] <= ex_target_i;
        btb_ctr[ex_idx]    <= ex_is_jump_i ? CTR_JUMP : CTR_BRANCH;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch PC register: redirect beats stall, stall beats prediction
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_o) begin
      pc_q <= correct_pc;
    end else if (!stall_i) begin
      pc_q <= pred_target_o;
    end
  end

  // ---------------------------------------------------------------------------
  // Mispredict statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (redirect_o && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign mispredict_cnt_o = cnt_q;

endmodule

// File: doc/next_pc_predictor.md
# next_pc_predictor

Fetch-stage next-PC generator for the pipelined core: holds the architectural fetch PC, predicts the next PC with a direct-mapped branch target buffer (BTB) and 2-bit saturating counters, and accepts resolution from the execute stage to redirect fetch and train the predictor. It replaces pure combinational PC+4/branch evaluation in fetch. Execute keeps its branch/JAL/JALR comparison logic, and its `jal_data` link value is still PC+4. The block is parametrised in address width, BTB depth and reset vector, and adds mispredict statistics.

## Interface
Parameters:
- `XLEN`, 32, address/data width.
- `BTB_ENTRIES`, 16, BTB depth; power of two, ≥2; `IDX = log2(BTB_ENTRIES)`.
- `RESET_PC`, 32'h0000_0000, fetch PC after reset (XLEN bits).

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `stall_i`  in  1  hold fetch PC (front-end stall).
- `pc_o`  out  XLEN  current fetch PC (registered).
- `pred_taken_o`  out  1  prediction for `pc_o` (combinational from `pc_o` and BTB).
- `pred_target_o`  out  XLEN  predicted next PC for `pc_o`: BTB target if `pred_taken_o`, else `pc_o`+4.
- `ex_valid_i`  in  1  execute-stage control-flow instruction resolved this cycle.
- `ex_is_jump_i`  in  1  instruction is JAL/JALR (else conditional branch).
- `ex_pc_i`  in  XLEN  PC of the resolving instruction.
- `ex_taken_i`  in  1  actual direction (1 for jumps).
- `ex_target_i`  in  XLEN  actual target (JALR already LSB-cleared).
- `ex_pred_taken_i`  in  1  prediction carried down the pipe with the instruction.
- `ex_pred_target_i`  in  XLEN  predicted next PC carried down the pipe.
- `redirect_o`  out  1  mispredict: younger instructions must be flushed.
- `mispredict_cnt_o`  out  32  saturating count of mispredicts.

## Operation
- BTB entry: `valid`, `tag` (`pc[XLEN-1:IDX+2]`), `target` (XLEN), `ctr` (2 bits). Index = `pc[IDX+1:2]`; `pc[1:0]` ignored.
- Lookup on `pc_o`: hit = valid && tag match. `pred_taken_o` = hit && `ctr[1]`.
- Mispredict (`redirect_o`=1) when `ex_valid_i` && (`ex_taken_i` != `ex_pred_taken_i` || (`ex_taken_i` && `ex_target_i` != `ex_pred_target_i`)). `redirect_o` is combinational and 0 when `ex_valid_i`=0.
- Correct PC = `ex_taken_i` ? `ex_target_i` : `ex_pc_i`+4. Addition wraps modulo 2^XLEN.
- PC register update priority: reset > `redirect_o` (load correct PC, ignores `stall_i`) > `stall_i` (hold) > load `pred_target_o`.
- Training on `ex_valid_i`, indexed by `ex_pc_i`:
  - Hit, taken: `ctr` saturating +1 (max 11), `target` <= `ex_target_i`.
  - Hit, not taken: `ctr` saturating −1 (min 00); target kept.
  - Miss, taken: allocate/overwrite: valid=1, tag, target; `ctr`=11 for jump, 10 for branch.
  - Miss, not taken: no change.
- Training is independent of `stall_i` and of whether the instruction mispredicted.
- `mispredict_cnt_o` increments on each `redirect_o` cycle and saturates at 32'hFFFF_FFFF.

## Timing
- Reset (async assert, sync-visible deassert): `pc_o`=`RESET_PC`, all `valid`=0, all `ctr`=01, `mispredict_cnt_o`=0. Hence `pred_taken_o`=0, `pred_target_o`=`RESET_PC`+4. `redirect_o` depends only on inputs.
- Prediction latency 0: `pred_*` reflect `pc_o` in the same cycle. PC advance latency 1: the redirected or predicted PC appears on `pc_o` the cycle after the edge.
- Same-cycle training write and lookup at the same index: the lookup sees pre-write state; the write is visible from the next cycle.
- `redirect_o` and `stall_i` together: redirect wins, and `pc_o` takes the correct PC next cycle.
- Reset asserted mid-operation: state clears immediately, and a pending redirect is discarded.
- Throughput: one PC per unstalled cycle, with no bubbles on correct predictions.

## Test plan
- Reset then 4 free-run cycles with `RESET_PC`=0x0 -> `pc_o` = 0x0, 0x4, 0x8, 0xC; `pred_taken_o`=0; `redirect_o`=0.
- Branch at 0x10, taken to 0x40, reported with pred_taken=0 -> `redirect_o`=1, `pc_o`=0x40 next cycle, count=1. At next fetch of 0x10: `pred_taken_o`=1, `pred_target_o`=0x40.
- Same branch resolved not-taken 3 times from ctr=10 -> ctr 01, 00, 00. `pred_taken_o`=0 after first; not-taken while predicted taken -> redirect to 0x14.
- JALR at 0x20 installed with target 0x100, then resolved with target 0x200 while predicted 0x100 -> redirect to 0x200, entry target updated to 0x200, ctr stays 11.
- Aliasing with `BTB_ENTRIES`=16: entry at 0x10 installed, fetch 0x50 (same index, different tag) -> `pred_taken_o`=0. Taken resolution at 0x50 overwrites the entry, and 0x10 then misses.
- `stall_i`=1 with a concurrent mispredict -> `pc_o` takes the correct PC. `stall_i`=1 alone for 3 cycles -> `pc_o` held. Reset pulsed mid-stream -> `pc_o`=`RESET_PC` and the BTB is empty.
